// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the FSM encoding and the external SRAM geometry.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } sram_state_t;

    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: splits each 32-bit request into two
// 16-bit asynchronous SRAM accesses and holds ready low while busy.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    sram_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   r_is_wr, w_is_wr_nxt;
    logic [16:0]            r_word, w_word_nxt;
    logic [31:0]            r_wdata, w_wdata_nxt;
    logic [31:0]            r_rdata, w_rdata_nxt;
    logic [SRAM_ADDR_W-1:0] r_sram_addr, w_sram_addr_nxt;
    logic [SRAM_DATA_W-1:0] r_dq_out, w_dq_out_nxt;
    logic                   r_dq_oe, w_dq_oe_nxt;
    logic                   r_we_n, w_we_n_nxt;
    logic                   w_ready;
    logic                   w_req;
    logic [31:0]            w_offset;
    logic [CNT_W-1:0]       w_cnt_dec;
    logic                   w_unused_addr;

    assign w_req     = wr_en | rd_en;
    assign w_offset  = address - 32'(BASE_ADDR);
    assign w_cnt_dec = r_cnt - 1'b1;
    // Only the word-index bits reach the SRAM; the rest of the address is ignored.
    assign w_unused_addr = &{1'b0, w_offset[31:19], w_offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_word      <= w_word_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_sram_addr <= w_sram_addr_nxt;
            r_dq_out    <= w_dq_out_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_we_n      <= w_we_n_nxt;
        end
    end

    // SRAM pins are registered, so each branch computes the pin values for the
    // state being entered rather than the state currently held.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_wr_nxt     = r_is_wr;
        w_word_nxt      = r_word;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_sram_addr_nxt = r_sram_addr;
        w_dq_out_nxt    = r_dq_out;
        w_dq_oe_nxt     = r_dq_oe;
        w_we_n_nxt      = r_we_n;
        w_ready         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_state_nxt     = S_LO;
                    w_cnt_nxt       = CNT_LOAD;
                    w_is_wr_nxt     = wr_en;
                    w_word_nxt      = w_offset[18:2];
                    w_wdata_nxt     = wdata;
                    w_sram_addr_nxt = {w_offset[18:2], 1'b0};
                    w_dq_out_nxt    = wdata[15:0];
                    w_dq_oe_nxt     = wr_en;
                    w_we_n_nxt      = ~wr_en;
                end
            end
            S_LO: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt  = w_cnt_dec;
                    // Strobe rises as the count reaches zero, while address/data are still held.
                    w_we_n_nxt = ~(r_is_wr && (w_cnt_dec != '0));
                end else begin
                    if (!r_is_wr) begin
                        w_rdata_nxt[15:0] = sram_dq_in;
                    end
                    w_state_nxt     = S_HI;
                    w_cnt_nxt       = CNT_LOAD;
                    w_sram_addr_nxt = {r_word, 1'b1};
                    w_dq_out_nxt    = r_wdata[31:16];
                    w_we_n_nxt      = ~r_is_wr;
                end
            end
            S_HI: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt  = w_cnt_dec;
                    w_we_n_nxt = ~(r_is_wr && (w_cnt_dec != '0));
                end else begin
                    if (!r_is_wr) begin
                        w_rdata_nxt[31:16] = sram_dq_in;
                    end
                    w_state_nxt = S_DONE;
                    w_dq_oe_nxt = 1'b0;
                    w_we_n_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_ready     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rdata       = r_rdata;
    assign ready       = w_ready;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: SRAM pin model, transaction-level
// reference model with a per-cycle compare, and directed literal checks.
module tb_sram_controller;

    localparam int A    = 2;
    localparam int LAST = 2 * A + 1;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int n_chk;
    int n_err;

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(A)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM pin model: latches on the rising write strobe.
    logic [15:0] mem_sram [0:255];
    logic [9:0]  unused_hi;
    assign unused_hi  = sram_addr[17:8];
    assign sram_dq_in = mem_sram[sram_addr[7:0]];
    initial for (int i = 0; i < 256; i++) mem_sram[i] = 16'h0000;
    always @(posedge sram_we_n) begin
        if (!rst && sram_dq_oe) mem_sram[sram_addr[7:0]] <= sram_dq_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t counts cycles since the request was accepted
    // (0 = idle, 1..2A = accessing, 2A+1 = completion cycle).
    int          m_t;
    logic        m_wr;
    logic [17:0] m_lo;
    logic [31:0] m_wd;
    logic [31:0] m_rdata;
    logic [15:0] m_mem [0:255];
    initial for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t     <= 0;
            m_rdata <= 32'h0;
        end else if (m_t == 0) begin
            if (wr_en || rd_en) begin
                m_t  <= 1;
                m_wr <= wr_en;
                m_lo <= 18'(((address - 32'd1024) / 4) * 2);
                m_wd <= wdata;
            end
        end else if (m_t == LAST) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
            if (m_t == LAST - 1) begin
                if (m_wr) begin
                    m_mem[m_lo[7:0]]        <= m_wd[15:0];
                    m_mem[m_lo[7:0] + 8'd1] <= m_wd[31:16];
                end else begin
                    m_rdata <= {m_mem[m_lo[7:0] + 8'd1], m_mem[m_lo[7:0]]};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic exp_rdy, exp_we_n, exp_oe;
            exp_rdy  = (m_t == 0) ? !(wr_en || rd_en) : (m_t == LAST);
            exp_we_n = !(m_wr && ((m_t >= 1 && m_t <= A - 1) || (m_t >= A + 1 && m_t <= 2 * A - 1)));
            exp_oe   = m_wr && (m_t >= 1) && (m_t <= 2 * A);
            chk("cyc_ready", {31'b0, ready}, {31'b0, exp_rdy});
            chk("cyc_we_n", {31'b0, sram_we_n}, {31'b0, exp_we_n});
            chk("cyc_oe", {31'b0, sram_dq_oe}, {31'b0, exp_oe});
            if (m_t >= 1 && m_t <= A) begin
                chk("cyc_addr_lo", {14'b0, sram_addr}, {14'b0, m_lo});
                if (m_wr) chk("cyc_dq_lo", {16'b0, sram_dq_out}, {16'b0, m_wd[15:0]});
            end
            if (m_t >= A + 1 && m_t <= 2 * A) begin
                chk("cyc_addr_hi", {14'b0, sram_addr}, {14'b0, m_lo + 18'd1});
                if (m_wr) chk("cyc_dq_hi", {16'b0, sram_dq_out}, {16'b0, m_wd[31:16]});
            end
            if (m_t == 0 || m_t == LAST) chk("cyc_rdata", rdata, m_rdata);
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the ready cycle.
    task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                          input bit hold, output int lat, output logic [31:0] rd);
        wr_en   = w;
        rd_en   = r;
        address = a;
        wdata   = d;
        lat     = 0;
        rd      = 32'hx;
        while (1) begin
            @(negedge clk);
            if (ready) begin
                rd = rdata;
                break;
            end
            lat++;
            if (lat > 20) begin
                chk("ready_timeout", 32'(lat), 32'd5);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        n_chk = 0; n_err = 0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'b0, sram_dq_oe}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, lat, rd);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_mem0", {16'b0, mem_sram[0]}, 32'h0000BEEF);
        chk("wr_mem1", {16'b0, mem_sram[1]}, 32'h0000DEAD);

        do_req(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, lat, rd);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_data", rd, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'd1036, 32'h12345678, 1'b0, lat, rd);
        chk("map_mem6", {16'b0, mem_sram[6]}, 32'h00005678);
        chk("map_mem7", {16'b0, mem_sram[7]}, 32'h00001234);
        do_req(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, lat, rd);
        chk("map_rd", rd, 32'h12345678);

        do_req(1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 1'b0, lat, rd);
        chk("both_rdata_kept", rd, 32'h12345678);
        chk("both_mem8", {16'b0, mem_sram[8]}, 32'h0000A5A5);
        chk("both_mem9", {16'b0, mem_sram[9]}, 32'h0000A5A5);

        // Abort a write during its first access cycle.
        wr_en = 1'b1; address = 32'd1036; wdata = 32'hFFFF0000;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("abort_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("abort_addr", {14'b0, sram_addr}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        #1 rst = 1'b0; wr_en = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, lat, rd);
        chk("abort_old_data", rd, 32'h12345678);

        // Reset in the middle of a read with the request withdrawn.
        rd_en = 1'b1; address = 32'd1024;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1; rd_en = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        chk("midrst_rdata", rdata, 32'h0);
        chk("midrst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("midrst_oe", {31'b0, sram_dq_oe}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back reads: second request held straight through ready.
        do_req(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, lat, rd);
        chk("b2b_rd0", rd, 32'hDEADBEEF);
        address = 32'd1040;
        #1;
        chk("b2b_nogap", {31'b0, ready}, 32'd0);
        do_req(1'b0, 1'b1, 32'd1040, 32'h0, 1'b0, lat, rd);
        chk("b2b_latency", 32'(lat), 32'd5);
        chk("b2b_rd1", rd, 32'hA5A5A5A5);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
